counter_bus_reader: RTL and testbench
=====================================

# counter_bus_reader

Periodic sampler and controller for an 8-bit synchronous counter that drives a shared tri-state count bus. It loads the counter with a preset value, then enables the counter's bus driver for a short window every SAMPLE_PERIOD cycles and captures the bus value. Each capture yields a delta and a wrap flag relative to the previous sample. Captures are offered to downstream logic through a valid/ready handshake, and the block sits on the reading end of the counter's load / output-enable / bus interface.

## Interface
- SAMPLE_PERIOD, 16: cycles between captures; legal range 3..255.
- SETTLE, 1: cycles `cnt_out_en` is held before the capture cycle; legal range 0..SAMPLE_PERIOD-2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; begins load-then-sample sequence from IDLE.
- stop  in  1  single-cycle pulse; returns to IDLE.
- preset_val  in  8  value loaded into counter; registered on accepted `start`.
- bus_in  in  8  shared count bus; valid only while `cnt_out_en`=1.
- cnt_load  out  1  load strobe to counter.
- cnt_out_en  out  1  output-enable to counter's bus driver.
- sample  out  8  last captured bus value.
- delta  out  8  (sample − previous sample) mod 256.
- wrap  out  1  1 when sample < previous sample (unsigned).
- sample_valid  out  1  capture available.
- sample_ready  in  1  downstream accepts capture.
- overrun  out  1  sticky; an unconsumed capture was overwritten.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - `start`=1 and `stop`=0 → LOAD, and `preset_val` is registered.
  - `start` is ignored in any other state.
  - `start` and `stop` in the same cycle → stay IDLE.
- LOAD (one cycle, call it cycle L):
  - `cnt_load`=1.
  - The previous-sample register is set to preset_val − 1 (mod 256).
  - The period timer is cleared.
  - → RUN.
- RUN:
  - The timer counts cycles since L.
  - Capture cycles are C = L + n·SAMPLE_PERIOD, n ≥ 1.
  - `cnt_out_en`=1 in cycles C−SETTLE..C inclusive, and 0 otherwise.
- Capture, at the edge ending cycle C:
  - sample ← bus_in.
  - delta ← bus_in − prev.
  - wrap ← (bus_in < prev).
  - prev ← bus_in.
  - sample_valid ← 1.
- Handshake:
  - Transfer occurs at any edge with sample_valid=1 and sample_ready=1.
  - After a transfer, valid drops unless a capture occurs at the same edge.
  - sample, delta and wrap are stable while valid=1 and not transferred.
- Overrun:
  - A capture while valid=1 and ready=0 overwrites all three outputs and sets `overrun`.
  - A capture with ready=1 at the same edge is a clean transfer-and-replace: valid stays 1, no overrun.
  - `overrun` is cleared only by reset or an accepted `start`.
- Stop:
  - `stop` in LOAD or RUN → IDLE at the next edge. `cnt_load` and `cnt_out_en` are 0 from the next cycle.
  - If `stop` coincides with a capture edge, the capture still completes.
  - A pending `sample_valid` is retained until transferred.
- Arithmetic: all 8-bit, modulo 256. The timer is wide enough for SAMPLE_PERIOD and does not saturate.

## Timing
- Reset (rst_n=0 at an edge):
  - State becomes IDLE.
  - cnt_load, cnt_out_en, sample_valid, overrun, busy, wrap are all 0.
  - sample and delta are 0x00.
  - prev is 0x00 and the timer is 0.
- Reset has priority over every other input. Reset mid-RUN drops `cnt_out_en` in the next cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` in cycle S → `cnt_load`=1 in cycle S+1 (= L). `busy`=1 from S+1.
- With a free-running counter, the bus in cycle L+k carries preset+k−1. The first capture therefore reads preset+SAMPLE_PERIOD−1, giving delta = SAMPLE_PERIOD mod 256 for every sample.
- Capture-to-valid latency is one edge: `sample_valid`=1 in cycle C+1.
- bus_in is never sampled in a cycle where `cnt_out_en`=0.

## Test plan
- Reset with all inputs at random values, rst_n=0 for 2 cycles → every output 0, busy=0.
- Defaults, preset_val=0x10, start, sample_ready=1 held:
  - cnt_load for exactly 1 cycle.
  - Samples 0x1F, 0x2F, 0x3F arrive 16 cycles apart, each with delta=0x10 and wrap=0.
  - cnt_out_en high 2 cycles per period.
- preset_val=0xF8, start, ready=1 → first sample 0x07 with wrap=1 and delta=0x10; second sample 0x17 with wrap=0.
- preset_val=0x00, ready=0 for 40 cycles:
  - sample_valid held with sample=0x0F through the second capture.
  - After the second capture, sample=0x1F and overrun=1.
  - ready=1 → valid drops next cycle; overrun stays 1 until the next start.
- Ready asserted exactly on a capture edge → valid remains 1, new sample presented, overrun=0.
- Stop and reset behaviour:
  - stop in mid-SETTLE window → cnt_out_en=0 next cycle, busy=0, no further captures.
  - start and stop in the same cycle from IDLE → stays IDLE.
  - rst_n=0 mid-RUN → all outputs 0 next cycle.

Source files
------------

// File: rtl/counter_bus_reader.sv
// Load-then-sample controller for an 8-bit counter on a shared count bus.
// Periodically enables the counter's bus driver, captures the value and offers it over valid/ready.
module counter_bus_reader #(
  parameter int unsigned SAMPLE_PERIOD = 16,
  parameter int unsigned SETTLE        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] preset_val,
  input  logic [7:0] bus_in,
  output logic       cnt_load,
  output logic       cnt_out_en,
  output logic [7:0] sample,
  output logic [7:0] delta,
  output logic       wrap,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [7:0] PERIOD  = 8'(SAMPLE_PERIOD);
  localparam logic [7:0] OE_FROM = 8'(SAMPLE_PERIOD - SETTLE);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] preset_q;
  logic [7:0] prev_q;
  logic       capture;
  logic       start_ok;
  logic       oe_d;

  assign start_ok = (state_q == IDLE) && start && !stop;

  // Timer holds the number of cycles since the LOAD cycle; wraps back to 1 on each capture.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: begin
        timer_d = 8'd1;
        state_d = stop ? IDLE : RUN;
      end
      RUN: begin
        capture = (timer_q == PERIOD);
        timer_d = capture ? 8'd1 : timer_q + 8'd1;
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    oe_d = (state_d == RUN) && (timer_d >= OE_FROM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      preset_q     <= '0;
      prev_q       <= '0;
      cnt_load     <= 1'b0;
      cnt_out_en   <= 1'b0;
      busy         <= 1'b0;
      sample       <= '0;
      delta        <= '0;
      wrap         <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_load   <= (state_d == LOAD);
      cnt_out_en <= oe_d;
      busy       <= (state_d != IDLE);

      if (start_ok) begin
        preset_q <= preset_val;
        overrun  <= 1'b0;
      end

      if (state_q == LOAD) prev_q <= preset_q - 8'd1;

      if (capture) begin
        sample       <= bus_in;
        delta        <= bus_in - prev_q;
        wrap         <= (bus_in < prev_q);
        prev_q       <= bus_in;
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready) overrun <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_bus_reader.sv
// Bench for counter_bus_reader: free-running counter model on the bus, table-driven runs
// checked through a scoreboard, plus hand-written overrun/stop/reset sequences.
module tb_counter_bus_reader;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, sample_ready;
  logic [7:0] preset_val, bus_in;
  logic       cnt_load, cnt_out_en, wrap, sample_valid, overrun, busy;
  logic [7:0] sample, delta;

  counter_bus_reader #(.SAMPLE_PERIOD(16), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .preset_val(preset_val),
    .bus_in(bus_in), .cnt_load(cnt_load), .cnt_out_en(cnt_out_en), .sample(sample),
    .delta(delta), .wrap(wrap), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter model: loads on cnt_load, otherwise counts; bus carries junk when not enabled.
  logic [7:0] preset_m = 8'h00;
  logic [7:0] cnt_m    = 8'h00;
  logic [7:0] junk     = 8'h00;
  always @(posedge clk) begin
    cnt_m <= cnt_load ? preset_m : cnt_m + 8'd1;
    junk  <= 8'($urandom);
  end
  assign bus_in = cnt_out_en ? cnt_m : junk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] s;
    logic [7:0] d;
    logic       w;
  } exp_t;

  typedef struct {
    logic [7:0] preset;
    logic [7:0] s1;
    logic [7:0] d1;
    logic       w1;
    logic [7:0] s2;
    logic [7:0] d2;
    logic       w2;
  } vec_t;

  exp_t sbq[$];
  logic sb_en     = 1'b0;
  logic first_pop = 1'b0;
  int   start_cyc = 0;
  int   last_cyc  = 0;
  int   load_cnt  = 0;
  int   oe_cnt    = 0;

  always @(negedge clk) begin
    if (cnt_load)   load_cnt++;
    if (cnt_out_en) oe_cnt++;
  end

  // Scoreboard: each transfer (valid & ready before the coming edge) pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_en && rst_n && sample_valid && sample_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_transfer", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_sample", int'(sample), int'(e.s));
        chk("sb_delta",  int'(delta),  int'(e.d));
        chk("sb_wrap",   int'(wrap),   int'(e.w));
        if (first_pop) chk("sb_first_latency", cyc - start_cyc, 18);
        else           chk("sb_interval",      cyc - last_cyc,  16);
        first_pop = 1'b0;
        last_cyc  = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h10, 8'h1F, 8'h10, 1'b0, 8'h2F, 8'h10, 1'b0};
    vecs[1] = '{8'hF8, 8'h07, 8'h10, 1'b1, 8'h17, 8'h10, 1'b0};
    vecs[2] = '{8'hF0, 8'hFF, 8'h10, 1'b0, 8'h0F, 8'h10, 1'b1};
    vecs[3] = '{8'h00, 8'h0F, 8'h10, 1'b1, 8'h1F, 8'h10, 1'b0};
    vecs[4] = '{8'hF1, 8'h00, 8'h10, 1'b1, 8'h10, 8'h10, 1'b0};

    // Reset with random inputs
    rst_n = 1'b0; start = 1'($urandom); stop = 1'($urandom);
    preset_val = 8'($urandom); sample_ready = 1'($urandom);
    step(2);
    chk("rst_cnt_load", cnt_load, 0);
    chk("rst_cnt_out_en", cnt_out_en, 0);
    chk("rst_sample", sample, 0);
    chk("rst_delta", delta, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; sample_ready = 1'b1;
    step(2);
    chk("idle_busy", busy, 0);

    // Table-driven runs through the scoreboard
    sb_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int npop;
      preset_m   = vecs[i].preset;
      preset_val = vecs[i].preset;
      sbq.push_back('{vecs[i].s1, vecs[i].d1, vecs[i].w1});
      sbq.push_back('{vecs[i].s2, vecs[i].d2, vecs[i].w2});
      npop = 2;
      if (i == 0) begin
        sbq.push_back('{8'h3F, 8'h10, 1'b0});
        npop = 3;
      end
      load_cnt  = 0;
      oe_cnt    = 0;
      first_pop = 1'b1;
      start_cyc = cyc;
      start = 1'b1; step(1); start = 1'b0;
      chk("tbl_load_in_L", cnt_load, 1);
      chk("tbl_busy_in_L", busy, 1);
      for (int k = 0; k < 100 && sbq.size() != 0; k++) step(1);
      chk("tbl_drained", sbq.size(), 0);
      sbq.delete();
      chk("tbl_load_cycles", load_cnt, 1);
      chk("tbl_oe_cycles", oe_cnt, 2 * npop);
      stop = 1'b1; step(1); stop = 1'b0;
      step(2);
      chk("tbl_stopped", busy, 0);
    end
    sb_en = 1'b0;

    // Overrun: preset 0x00, ready held low through two captures
    sample_ready = 1'b0;
    preset_m = 8'h00; preset_val = 8'h00;
    start = 1'b1; step(1); start = 1'b0;
    chk("ovr_load", cnt_load, 1);
    step(1);
    chk("ovr_load_one_cycle", cnt_load, 0);
    step(16);
    chk("ovr_valid1", sample_valid, 1);
    chk("ovr_sample1", sample, 8'h0F);
    chk("ovr_delta1", delta, 8'h10);
    chk("ovr_wrap1", wrap, 1);
    chk("ovr_not_yet", overrun, 0);
    step(15);
    chk("ovr_hold_valid", sample_valid, 1);
    chk("ovr_hold_sample", sample, 8'h0F);
    step(1);
    chk("ovr_sample2", sample, 8'h1F);
    chk("ovr_delta2", delta, 8'h10);
    chk("ovr_wrap2", wrap, 0);
    chk("ovr_set", overrun, 1);
    chk("ovr_valid2", sample_valid, 1);
    step(6);
    sample_ready = 1'b1; step(1); sample_ready = 1'b0;
    chk("ovr_valid_drop", sample_valid, 0);
    chk("ovr_sticky", overrun, 1);
    step(4);
    chk("ovr_sticky2", overrun, 1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("ovr_stop_busy", busy, 0);
    chk("ovr_sticky_idle", overrun, 1);
    start = 1'b1; step(1); start = 1'b0;
    chk("ovr_cleared_by_start", overrun, 0);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("ovr_stop2", busy, 0);

    // Ready exactly on a capture edge
    preset_m = 8'h40; preset_val = 8'h40;
    start = 1'b1; step(1); start = 1'b0;
    step(17);
    chk("rdy_valid1", sample_valid, 1);
    chk("rdy_sample1", sample, 8'h4F);
    step(15);
    sample_ready = 1'b1; step(1); sample_ready = 1'b0;
    chk("rdy_valid_kept", sample_valid, 1);
    chk("rdy_sample2", sample, 8'h5F);
    chk("rdy_no_overrun", overrun, 0);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("rdy_stop_busy", busy, 0);
    step(3);
    chk("rdy_pending_retained", sample_valid, 1);
    sample_ready = 1'b1; step(1); sample_ready = 1'b0;
    chk("rdy_pending_taken", sample_valid, 0);

    // Stop on the capture edge: capture still completes
    preset_m = 8'h30; preset_val = 8'h30;
    start = 1'b1; step(1); start = 1'b0;
    step(16);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stopcap_busy", busy, 0);
    chk("stopcap_oe", cnt_out_en, 0);
    chk("stopcap_valid", sample_valid, 1);
    chk("stopcap_sample", sample, 8'h3F);
    sample_ready = 1'b1; step(1); sample_ready = 1'b0;
    chk("stopcap_taken", sample_valid, 0);

    // Stop in the settle window
    preset_m = 8'h20; preset_val = 8'h20;
    start = 1'b1; step(1); start = 1'b0;
    step(14);
    chk("settle_oe_off_before", cnt_out_en, 0);
    step(1);
    chk("settle_oe_on", cnt_out_en, 1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("settle_oe_dropped", cnt_out_en, 0);
    chk("settle_busy", busy, 0);
    step(30);
    chk("settle_no_capture", sample_valid, 0);
    chk("settle_oe_idle", cnt_out_en, 0);

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_load", cnt_load, 0);
    step(2);
    chk("ss_busy_later", busy, 0);

    // Reset mid-RUN
    preset_m = 8'h50; preset_val = 8'h50;
    start = 1'b1; step(1); start = 1'b0;
    step(31);
    chk("mrst_pre_oe", cnt_out_en, 1);
    chk("mrst_pre_valid", sample_valid, 1);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("mrst_cnt_load", cnt_load, 0);
    chk("mrst_oe", cnt_out_en, 0);
    chk("mrst_sample", sample, 0);
    chk("mrst_delta", delta, 0);
    chk("mrst_wrap", wrap, 0);
    chk("mrst_valid", sample_valid, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_busy", busy, 0);
    step(20);
    chk("mrst_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
